lab3_3_stim_sampler: RTL and testbench

LAB3_3_STIM_SAMPLER -- requirements
Module: lab3_3_stim_sampler

---
 rtl/lab3_3_stim_sampler.sv | 115 +++++++++++
 tb/tb_lab3_3_stim_sampler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lab3_3_stim_sampler.sv
// Truth-table stimulus sampler: steps {in1,in2} through 00..11, lets each vector settle,
// captures out3 per vector and compares the captured table against EXPECTED.
// The captured-table port is named tbl because "table" is a reserved word in SystemVerilog.
module lab3_3_stim_sampler #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter logic [3:0]  EXPECTED      = 4'b1111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       out3,
    output logic       in1,
    output logic       in2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] tbl
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t     state_r;
    logic [1:0] idx_r;
    logic [7:0] cnt_r;
    logic [1:0] idx_next_s;
    logic [3:0] captured_s;

    // An X/Z in the table makes the equality unknown, which falls through to the mismatch branch.
    function automatic logic table_matches(input logic [3:0] t);
        if (t == EXPECTED) begin
            return 1'b1;
        end else begin
            return 1'b0;
        end
    endfunction

    // Table as it will look once the current vector's out3 sample is written in.
    always_comb begin
        captured_s        = tbl;
        captured_s[idx_r] = out3;
        idx_next_s        = idx_r + 2'd1;
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= 2'd0;
            cnt_r   <= 8'd0;
            in1     <= 1'b0;
            in2     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            tbl     <= 4'b0000;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_r <= SETTLE;
                        idx_r   <= 2'd0;
                        in1     <= 1'b0;
                        in2     <= 1'b0;
                        cnt_r   <= SETTLE_LOAD;
                        tbl     <= 4'b0000;
                        pass    <= 1'b0;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SETTLE: begin
                    if (cnt_r == 8'd0) begin
                        state_r <= SAMPLE;
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                SAMPLE: begin
                    tbl <= captured_s;
                    if (idx_r == 2'd3) begin
                        state_r <= DONE;
                        done    <= 1'b1;
                        pass    <= table_matches(captured_s);
                    end else begin
                        state_r <= SETTLE;
                        idx_r   <= idx_next_s;
                        in1     <= idx_next_s[1];
                        in2     <= idx_next_s[0];
                        cnt_r   <= SETTLE_LOAD;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lab3_3_stim_sampler.sv
// Bench for lab3_3_stim_sampler: an S=16 instance (a) and an S=1 instance (b), each driven
// by a modelled gate network, checked with vector tables, random runs and corner sequences.
module tb_lab3_3_stim_sampler;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_b;
    logic       out3_a, in1_a, in2_a, busy_a, done_a, pass_a;
    logic       out3_b, in1_b, in2_b, busy_b, done_b, pass_b;
    logic [3:0] tbl_a, tbl_b;
    logic [3:0] net_a, net_b;
    logic       fault_a;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Downstream gate network: truth table net, optionally stuck at 0 on vector 10.
    assign out3_a = (fault_a && {in1_a, in2_a} == 2'b10) ? 1'b0 : net_a[{in1_a, in2_a}];
    assign out3_b = net_b[{in1_b, in2_b}];

    lab3_3_stim_sampler #(.SETTLE_CYCLES(16)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .out3(out3_a),
        .in1(in1_a), .in2(in2_a), .busy(busy_a), .done(done_a), .pass(pass_a), .tbl(tbl_a)
    );

    lab3_3_stim_sampler #(.SETTLE_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .out3(out3_b),
        .in1(in1_b), .in2(in2_b), .busy(busy_b), .done(done_b), .pass(pass_b), .tbl(tbl_b)
    );

    typedef struct {
        logic [3:0] net;
        logic       fault;
        logic [3:0] exp_tbl;
        logic       exp_pass;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] get_vec(input int w);
        return (w == 1) ? {in1_b, in2_b} : {in1_a, in2_a};
    endfunction
    function automatic logic get_done(input int w);
        return (w == 1) ? done_b : done_a;
    endfunction
    function automatic logic get_busy(input int w);
        return (w == 1) ? busy_b : busy_a;
    endfunction
    function automatic logic get_pass(input int w);
        return (w == 1) ? pass_b : pass_a;
    endfunction
    function automatic logic [3:0] get_tbl(input int w);
        return (w == 1) ? tbl_b : tbl_a;
    endfunction

    // Reference: the table is simply what the network answers for each of the four vectors.
    function automatic logic [3:0] model_table(input logic [3:0] net, input logic fault);
        logic [3:0] t;
        for (int v = 0; v < 4; v++) begin
            t[v] = (fault && v == 2) ? 1'b0 : net[v];
        end
        return t;
    endfunction

    task automatic pulse_start(input int w);
        @(negedge clk);
        if (w == 1) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // One full run: checks start-edge state, vector step times, done latency, results, hold.
    task automatic run(input int w, input string name, input int s,
                       input logic [3:0] exp_tbl, input logic exp_pass);
        int         n;
        int         steps[$];
        logic [1:0] prev, cur;
        pulse_start(w);
        check({name, "_busy_on"}, get_busy(w), 1);
        check({name, "_vec0"}, get_vec(w), 2'b00);
        check({name, "_tbl_clr"}, get_tbl(w), 4'b0000);
        check({name, "_pass_clr"}, get_pass(w), 0);
        n    = 1;
        prev = get_vec(w);
        while (!get_done(w) && n < 400) begin
            @(negedge clk);
            n++;
            cur = get_vec(w);
            if (cur != prev) begin
                steps.push_back(n);
                check({name, "_vec_step"}, cur, prev + 2'd1);
                prev = cur;
            end
        end
        check({name, "_latency"}, n, 1 + 4 * (s + 1));
        check({name, "_nsteps"}, steps.size(), 3);
        for (int i = 0; i < steps.size() && i < 3; i++) begin
            check({name, "_step_time"}, steps[i], 1 + (i + 1) * (s + 1));
        end
        check({name, "_tbl"}, get_tbl(w), exp_tbl);
        check({name, "_pass"}, get_pass(w), exp_pass);
        @(negedge clk);
        check({name, "_done_1cyc"}, get_done(w), 0);
        check({name, "_busy_off"}, get_busy(w), 0);
        repeat (3) @(negedge clk);
        check({name, "_hold_tbl"}, get_tbl(w), exp_tbl);
        check({name, "_hold_pass"}, get_pass(w), exp_pass);
        check({name, "_hold_vec"}, get_vec(w), 2'b11);
    endtask

    vec_t vecs[4];

    initial begin
        int         dones;
        logic [3:0] r_net;
        logic       r_fault;

        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        net_a   = 4'b1111;
        net_b   = 4'b1111;
        fault_a = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_pass", pass_a, 0);
        check("rst_tbl", tbl_a, 4'b0000);
        check("rst_vec", {in1_a, in2_a}, 2'b00);
        rst = 1'b0;

        vecs[0] = '{net: 4'b1111, fault: 1'b0, exp_tbl: 4'b1111, exp_pass: 1'b1};
        vecs[1] = '{net: 4'b1111, fault: 1'b1, exp_tbl: 4'b1011, exp_pass: 1'b0};
        vecs[2] = '{net: 4'b0110, fault: 1'b0, exp_tbl: 4'b0110, exp_pass: 1'b0};
        vecs[3] = '{net: 4'b1110, fault: 1'b0, exp_tbl: 4'b1110, exp_pass: 1'b0};
        for (int i = 0; i < 4; i++) begin
            net_a   = vecs[i].net;
            fault_a = vecs[i].fault;
            run(0, $sformatf("vec%0d", i), 16, vecs[i].exp_tbl, vecs[i].exp_pass);
        end
        fault_a = 1'b0;
        net_a   = 4'b1111;

        // Minimum settle on instance b.
        run(1, "s1_nominal", 1, 4'b1111, 1'b1);

        // Random networks on both instances.
        for (int r = 0; r < 10; r++) begin
            r_net   = 4'($urandom_range(0, 15));
            net_b   = r_net;
            run(1, $sformatf("rnd_b%0d", r), 1, model_table(r_net, 1'b0),
                model_table(r_net, 1'b0) == 4'b1111);
        end
        for (int r = 0; r < 3; r++) begin
            r_net   = 4'($urandom_range(0, 15));
            r_fault = 1'($urandom_range(0, 1));
            net_a   = r_net;
            fault_a = r_fault;
            run(0, $sformatf("rnd_a%0d", r), 16, model_table(r_net, r_fault),
                model_table(r_net, r_fault) == 4'b1111);
        end
        net_a   = 4'b1111;
        fault_a = 1'b0;

        // Start while busy: extra start at cycle 5 and during DONE must be ignored.
        pulse_start(0);
        dones = 0;
        for (int n = 1; n < 120; n++) begin
            if (done_a) begin
                dones++;
                start_a = 1'b1;
            end else if (n == 5) begin
                start_a = 1'b1;
            end else begin
                start_a = 1'b0;
            end
            @(negedge clk);
        end
        start_a = 1'b0;
        check("busy_start_dones", dones, 1);
        check("busy_start_idle", busy_a, 0);

        // Reset during SETTLE of vector 1: everything clears and the run does not resume.
        pulse_start(0);
        repeat (20) @(negedge clk);
        check("midrst_pre_vec", {in1_a, in2_a}, 2'b01);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", busy_a, 0);
        check("midrst_vec", {in1_a, in2_a}, 2'b00);
        check("midrst_tbl", tbl_a, 4'b0000);
        check("midrst_pass", pass_a, 0);
        dones = 0;
        for (int n = 0; n < 90; n++) begin
            @(negedge clk);
            if (done_a || busy_a) dones++;
        end
        check("midrst_no_resume", dones, 0);
        run(0, "post_rst", 16, 4'b1111, 1'b1);

        // Simultaneous rst and start in IDLE: reset wins.
        @(negedge clk);
        rst     = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        start_a = 1'b0;
        check("rst_start_busy", busy_a, 0);
        check("rst_start_pass", pass_a, 0);
        repeat (3) @(negedge clk);
        check("rst_start_idle", busy_a, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
